// File: rtl/uart_wrapper.sv
// UART front end for a host command channel: receives two-byte commands and
// transmits one-byte responses, 8N1 framing at a programmable bit period.
module uart_wrapper (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    input  logic [15:0] baud_cnt,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent,
    output logic        tx_busy
);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic       {WAIT_HI, WAIT_LO} asm_state_t;

    // Bit periods shorter than 4 clocks would break mid-bit sampling.
    function automatic logic [15:0] clamp_period(input logic [15:0] b);
        return (b < 16'd4) ? 16'd4 : b;
    endfunction

    logic        rx_meta_q, rx_sync_q;
    rx_state_t   rx_state_q, rx_state_d;
    logic [15:0] rx_period_q, rx_period_d, rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d, rx_byte_q, rx_byte_d;
    logic        rx_strobe_q, rx_strobe_d;

    asm_state_t  asm_q, asm_d;
    logic [15:0] cmd_q, cmd_d;
    logic        cmd_rdy_q, cmd_rdy_d;

    tx_state_t   tx_state_q, tx_state_d;
    logic [15:0] tx_period_q, tx_period_d, tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_q, tx_d, tx_busy_q, tx_busy_d, resp_sent_q, resp_sent_d;
    logic        tx_accept_s, tx_last_s, rx_last_s;

    // Two-flop synchronizer, idle-high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
        end
    end

    assign rx_last_s = (rx_cnt_q == rx_period_q - 16'd1);

    // Receive FSM: half-period start check, then one sample per bit period.
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_period_d = rx_period_q;
        rx_cnt_d    = rx_cnt_q + 16'd1;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_byte_d   = rx_byte_q;
        rx_strobe_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = 16'd0;
                if (!rx_sync_q) begin
                    rx_state_d  = RX_START;
                    rx_period_d = clamp_period(baud_cnt);
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_cnt_q == {1'b0, rx_period_q[15:1]} - 16'd1) begin
                    rx_cnt_d   = 16'd0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_state_d = RX_START;
                end
            end
            RX_DATA: begin
                if (rx_last_s) begin
                    rx_cnt_d   = 16'd0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    rx_state_d = (rx_bit_q == 3'd7) ? RX_STOP : RX_DATA;
                end else begin
                    rx_state_d = RX_DATA;
                end
            end
            RX_STOP: begin
                if (rx_last_s) begin
                    rx_cnt_d   = 16'd0;
                    rx_state_d = RX_IDLE;
                    if (rx_sync_q) begin
                        rx_strobe_d = 1'b1;
                        rx_byte_d   = rx_shift_q;
                    end else begin
                        rx_strobe_d = 1'b0;
                    end
                end else begin
                    rx_state_d = RX_STOP;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Receive state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q  <= RX_IDLE;
            rx_period_q <= 16'd4;
            rx_cnt_q    <= 16'd0;
            rx_bit_q    <= 3'd0;
            rx_shift_q  <= 8'h00;
            rx_byte_q   <= 8'h00;
            rx_strobe_q <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            rx_period_q <= rx_period_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_byte_q   <= rx_byte_d;
            rx_strobe_q <= rx_strobe_d;
        end
    end

    // Command assembly; a pending command blocks new bytes until cleared.
    always_comb begin
        asm_d     = asm_q;
        cmd_d     = cmd_q;
        cmd_rdy_d = cmd_rdy_q;
        if (cmd_rdy_q) begin
            asm_d     = WAIT_HI;
            cmd_rdy_d = !clr_cmd_rdy;
        end else if (rx_strobe_q) begin
            case (asm_q)
                WAIT_HI: begin
                    cmd_d = {rx_byte_q, cmd_q[7:0]};
                    asm_d = WAIT_LO;
                end
                WAIT_LO: begin
                    cmd_d     = {cmd_q[15:8], rx_byte_q};
                    cmd_rdy_d = 1'b1;
                    asm_d     = WAIT_HI;
                end
                default: asm_d = WAIT_HI;
            endcase
        end else begin
            asm_d = asm_q;
        end
    end

    // Assembly registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_q     <= WAIT_HI;
            cmd_q     <= 16'h0000;
            cmd_rdy_q <= 1'b0;
        end else begin
            asm_q     <= asm_d;
            cmd_q     <= cmd_d;
            cmd_rdy_q <= cmd_rdy_d;
        end
    end

    // Busy drops during the last stop clock, so a request then starts the next frame seamlessly.
    assign tx_accept_s = send_resp && !tx_busy_q;
    assign tx_last_s   = (tx_cnt_q == tx_period_q - 16'd1);

    // Transmit FSM.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_period_d = tx_period_q;
        tx_cnt_d    = tx_cnt_q + 16'd1;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        tx_d        = tx_q;
        tx_busy_d   = tx_busy_q;
        resp_sent_d = 1'b0;
        if (tx_accept_s) begin
            tx_state_d  = TX_START;
            tx_period_d = clamp_period(baud_cnt);
            tx_cnt_d    = 16'd0;
            tx_shift_d  = resp;
            tx_d        = 1'b0;
            tx_busy_d   = 1'b1;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    tx_cnt_d = 16'd0;
                    tx_d     = 1'b1;
                end
                TX_START: begin
                    if (tx_last_s) begin
                        tx_state_d = TX_DATA;
                        tx_cnt_d   = 16'd0;
                        tx_bit_d   = 3'd0;
                        tx_d       = tx_shift_q[0];
                    end else begin
                        tx_state_d = TX_START;
                    end
                end
                TX_DATA: begin
                    if (tx_last_s) begin
                        tx_cnt_d = 16'd0;
                        if (tx_bit_q == 3'd7) begin
                            tx_state_d = TX_STOP;
                            tx_d       = 1'b1;
                        end else begin
                            tx_bit_d   = tx_bit_q + 3'd1;
                            tx_shift_d = {1'b0, tx_shift_q[7:1]};
                            tx_d       = tx_shift_q[1];
                        end
                    end else begin
                        tx_state_d = TX_DATA;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_q == tx_period_q - 16'd2) begin
                        resp_sent_d = 1'b1;
                        tx_busy_d   = 1'b0;
                    end else if (tx_last_s) begin
                        tx_state_d = TX_IDLE;
                        tx_cnt_d   = 16'd0;
                    end else begin
                        tx_state_d = TX_STOP;
                    end
                end
                default: tx_state_d = TX_IDLE;
            endcase
        end
    end

    // Transmit registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q  <= TX_IDLE;
            tx_period_q <= 16'd4;
            tx_cnt_q    <= 16'd0;
            tx_bit_q    <= 3'd0;
            tx_shift_q  <= 8'h00;
            tx_q        <= 1'b1;
            tx_busy_q   <= 1'b0;
            resp_sent_q <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_period_q <= tx_period_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_q        <= tx_d;
            tx_busy_q   <= tx_busy_d;
            resp_sent_q <= resp_sent_d;
        end
    end

    assign TX        = tx_q;
    assign cmd       = cmd_q;
    assign cmd_rdy   = cmd_rdy_q;
    assign resp_sent = resp_sent_q;
    assign tx_busy   = tx_busy_q;

endmodule

// File: tb/tb_uart_wrapper.sv
// Directed bench for uart_wrapper: host-side RX frames, TX waveform timing,
// loopback at the minimum period and mid-frame reset.
module tb_uart_wrapper;

    logic        clk = 1'b0;
    logic        rst, rx_drv, loop_en, rx_s, tx;
    logic [15:0] baud, cmd;
    logic [7:0]  resp;
    logic        send_resp, clr, cmd_rdy, resp_sent, tx_busy;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign rx_s = loop_en ? tx : rx_drv;

    uart_wrapper dut (
        .clk         (clk),
        .rst         (rst),
        .RX          (rx_s),
        .TX          (tx),
        .baud_cnt    (baud),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr),
        .resp        (resp),
        .send_resp   (send_resp),
        .resp_sent   (resp_sent),
        .tx_busy     (tx_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic host_byte(input logic [7:0] b, input logic stop_b, input int per);
        rx_drv = 1'b0;
        tick(per);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            tick(per);
        end
        rx_drv = stop_b;
        tick(per);
        rx_drv = 1'b1;
        tick(2 * per);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
    endtask

    // Sends one response and checks every bit edge; returns in the resp_sent cycle.
    task automatic run_tx(input logic [7:0] r, input int per, input int chg_k, input logic [15:0] chg_val);
        logic [9:0] frame;
        int         idx;
        frame     = {1'b1, r, 1'b0};
        resp      = r;
        send_resp = 1'b1;
        tick(1);
        resp      = 8'h00;
        for (int k = 1; k <= 10 * per; k++) begin
            if (k > 1) tick(1);
            if (k == 8) begin
                send_resp = 1'b1;
                resp      = 8'hFF;
            end else begin
                send_resp = 1'b0;
            end
            if (k == chg_k) baud = chg_val;
            idx = (k - 1) / per;
            if (((k - 1) % per == 0) || (k % per == 0))
                check($sformatf("tx_%0h_bit%0d_k%0d", r, idx, k), 32'(tx), 32'(frame[idx]));
            if (k == 10 * per - 1) begin
                check("resp_sent_early", 32'(resp_sent), 32'h0);
                check("busy_in_frame", 32'(tx_busy), 32'h1);
            end
            if (k == 10 * per) begin
                check("resp_sent_pulse", 32'(resp_sent), 32'h1);
                check("busy_at_end", 32'(tx_busy), 32'h0);
            end
        end
        send_resp = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rx_drv = 1'b1; loop_en = 1'b0; baud = 16'd16;
        resp = 8'h00; send_resp = 1'b0; clr = 1'b0;
        tick(3);
        check("rst_tx", 32'(tx), 32'h1);
        check("rst_cmd", 32'(cmd), 32'h0);
        check("rst_rdy", 32'(cmd_rdy), 32'h0);
        check("rst_busy", 32'(tx_busy), 32'h0);
        check("rst_sent", 32'(resp_sent), 32'h0);
        rst = 1'b0;
        tick(2);

        host_byte(8'h45, 1'b1, 16);
        check("hi_cmd", 32'(cmd), 32'h4500);
        check("hi_rdy", 32'(cmd_rdy), 32'h0);
        host_byte(8'h03, 1'b1, 16);
        check("cmd_4503", 32'(cmd), 32'h4503);
        check("rdy_4503", 32'(cmd_rdy), 32'h1);

        host_byte(8'hAA, 1'b1, 16);
        host_byte(8'hBB, 1'b1, 16);
        check("held_cmd", 32'(cmd), 32'h4503);
        check("held_rdy", 32'(cmd_rdy), 32'h1);
        pulse_clr();
        check("clr_rdy", 32'(cmd_rdy), 32'h0);
        check("clr_cmd", 32'(cmd), 32'h4503);
        pulse_clr();
        check("clr_idle_rdy", 32'(cmd_rdy), 32'h0);
        host_byte(8'h01, 1'b1, 16);
        host_byte(8'h02, 1'b1, 16);
        check("cmd_0102", 32'(cmd), 32'h0102);
        check("rdy_0102", 32'(cmd_rdy), 32'h1);

        pulse_clr();
        rx_drv = 1'b0;
        tick(5);
        rx_drv = 1'b1;
        tick(40);
        check("glitch_rdy", 32'(cmd_rdy), 32'h0);
        check("glitch_cmd", 32'(cmd), 32'h0102);
        host_byte(8'h55, 1'b0, 16);
        check("frerr_cmd", 32'(cmd), 32'h0102);
        check("frerr_rdy", 32'(cmd_rdy), 32'h0);
        host_byte(8'h12, 1'b1, 16);
        host_byte(8'h34, 1'b1, 16);
        check("cmd_1234", 32'(cmd), 32'h1234);
        check("rdy_1234", 32'(cmd_rdy), 32'h1);
        pulse_clr();

        run_tx(8'hA5, 16, 0, 16'd0);
        tick(5);
        run_tx(8'h0F, 16, 20, 16'd32);
        run_tx(8'hF0, 32, 0, 16'd0);
        tick(5);
        check("idle_tx", 32'(tx), 32'h1);

        baud    = 16'd2;
        loop_en = 1'b1;
        run_tx(8'h3C, 4, 0, 16'd0);
        run_tx(8'h3C, 4, 0, 16'd0);
        tick(5);
        check("loop_cmd", 32'(cmd), 32'h3C3C);
        check("loop_rdy", 32'(cmd_rdy), 32'h1);
        pulse_clr();
        run_tx(8'h3C, 4, 0, 16'd0);
        tick(5);
        resp      = 8'h3C;
        send_resp = 1'b1;
        tick(1);
        send_resp = 1'b0;
        tick(14);
        rst = 1'b1;
        #1;
        check("mid_rst_tx", 32'(tx), 32'h1);
        check("mid_rst_cmd", 32'(cmd), 32'h0);
        check("mid_rst_rdy", 32'(cmd_rdy), 32'h0);
        check("mid_rst_busy", 32'(tx_busy), 32'h0);
        check("mid_rst_sent", 32'(resp_sent), 32'h0);
        tick(2);
        rst = 1'b0;
        tick(5);
        check("post_rst_tx", 32'(tx), 32'h1);
        run_tx(8'h5A, 4, 0, 16'd0);
        run_tx(8'hC3, 4, 0, 16'd0);
        tick(5);
        check("post_rst_cmd", 32'(cmd), 32'h5AC3);
        check("post_rst_rdy", 32'(cmd_rdy), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
